// File: rtl/io_periph_bank_if.sv
// ============================================================================
// Module      : io_periph_bank_if
// Description : Command/response bus between the CPU IO decode and the
//               peripheral register bank.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface io_periph_bank_if #(
    parameter int unsigned WL      = 32,
    parameter int unsigned ADDR_WL = 4
) ();
    logic                 cmd_valid;
    logic                 cmd_wr;
    logic [ADDR_WL-1:0]   cmd_addr;
    logic [WL-1:0]        cmd_wdata;
    logic [WL/8-1:0]      cmd_be;
    logic                 rsp_valid;
    logic [WL-1:0]        rsp_data;
    logic                 rsp_error;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
        input  rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
        output rsp_valid, rsp_data, rsp_error
    );
endinterface

`default_nettype wire

// File: rtl/io_periph_bank.sv
// ============================================================================
// Module      : io_periph_bank
// Description : Parametrised IO register bank: scratch, LEDs, switches,
//               sticky button events with IRQ, and per-channel RGB PWM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module io_periph_bank #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned WL       = 32,
    parameter int unsigned ADDR_WL  = 4,
    parameter int unsigned LED_W    = 4,
    parameter int unsigned SW_W     = 4,
    parameter int unsigned BTN_W    = 4,
    parameter int unsigned RGB_CH   = 2,
    parameter int unsigned PWM_FREQ = 20000
) (
    input  wire logic                clk,
    input  wire logic                reset,
    io_periph_bank_if.slave          bus,
    input  wire logic [SW_W-1:0]     sw,
    input  wire logic [BTN_W-1:0]    btn,
    output logic      [LED_W-1:0]    leds,
    output logic      [3*RGB_CH-1:0] rgb,
    output logic                     irq
);

    localparam int unsigned C_PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned C_PWM_WL = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;

    localparam logic [ADDR_WL-1:0] C_ADDR_SCRATCH = ADDR_WL'(0);
    localparam logic [ADDR_WL-1:0] C_ADDR_LEDS    = ADDR_WL'(1);
    localparam logic [ADDR_WL-1:0] C_ADDR_SW      = ADDR_WL'(2);
    localparam logic [ADDR_WL-1:0] C_ADDR_BTNLVL  = ADDR_WL'(3);
    localparam logic [ADDR_WL-1:0] C_ADDR_BTNEVT  = ADDR_WL'(4);
    localparam logic [ADDR_WL-1:0] C_ADDR_IRQEN   = ADDR_WL'(5);
    localparam logic [C_PWM_WL-1:0] C_CNT_MAX     = C_PWM_WL'(C_PERIOD - 1);

    logic [WL-1:0]       w_bemask;
    logic                w_wr;
    logic                w_rd;
    logic [BTN_W-1:0]    w_btn_edge;
    logic [BTN_W-1:0]    w_evt_clr;
    logic                w_cnt_wrap;
    logic [RGB_CH-1:0]   w_pwm;
    logic [WL-1:0]       w_rdata;
    logic                w_rerr;

    logic [WL-1:0]       r_scratch;
    logic [LED_W-1:0]    r_leds;
    logic [SW_W-1:0]     r_sw_meta;
    logic [SW_W-1:0]     r_sw_sync;
    logic [BTN_W-1:0]    r_btn_q;
    logic                r_btn_armed;
    logic [BTN_W-1:0]    r_btn_evt;
    logic [BTN_W-1:0]    r_irq_en;
    logic                r_irq;
    logic [2:0]          r_color  [RGB_CH];
    logic [C_PWM_WL-1:0] r_dcycle [RGB_CH];
    logic [C_PWM_WL-1:0] r_duty   [RGB_CH];
    logic [C_PWM_WL-1:0] r_cnt;
    logic [3*RGB_CH-1:0] r_rgb;
    logic                r_rsp_valid;
    logic [WL-1:0]       r_rsp_data;
    logic                r_rsp_error;

    genvar gi;
    generate
        for (gi = 0; gi < int'(WL / 8); gi++) begin : g_be
            assign w_bemask[8*gi +: 8] = {8{bus.cmd_be[gi]}};
        end
    endgenerate

    assign w_wr = bus.cmd_valid & bus.cmd_wr;
    assign w_rd = bus.cmd_valid & ~bus.cmd_wr;

    // A button held high across reset release must not look like a fresh edge.
    assign w_btn_edge = btn & ~r_btn_q & {BTN_W{r_btn_armed}};
    assign w_evt_clr  = (w_wr && bus.cmd_addr == C_ADDR_BTNEVT)
                        ? (bus.cmd_wdata[BTN_W-1:0] & w_bemask[BTN_W-1:0])
                        : '0;
    assign w_cnt_wrap = (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scratch   <= '0;
            r_leds      <= '0;
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_btn_q     <= '0;
            r_btn_armed <= 1'b0;
            r_btn_evt   <= '0;
            r_irq_en    <= '0;
            r_irq       <= 1'b0;
            for (int n = 0; n < int'(RGB_CH); n++) begin
                r_color[n]  <= '0;
                r_dcycle[n] <= '0;
            end
        end else begin
            r_sw_meta   <= sw;
            r_sw_sync   <= r_sw_meta;
            r_btn_q     <= btn;
            r_btn_armed <= 1'b1;
            // Set is applied after clear so a coincident edge wins.
            r_btn_evt   <= (r_btn_evt & ~w_evt_clr) | w_btn_edge;
            r_irq       <= |(r_btn_evt & r_irq_en);
            if (w_wr && bus.cmd_addr == C_ADDR_SCRATCH)
                r_scratch <= (r_scratch & ~w_bemask) | (bus.cmd_wdata & w_bemask);
            if (w_wr && bus.cmd_addr == C_ADDR_LEDS)
                r_leds <= (r_leds & ~w_bemask[LED_W-1:0])
                        | (bus.cmd_wdata[LED_W-1:0] & w_bemask[LED_W-1:0]);
            if (w_wr && bus.cmd_addr == C_ADDR_IRQEN)
                r_irq_en <= (r_irq_en & ~w_bemask[BTN_W-1:0])
                          | (bus.cmd_wdata[BTN_W-1:0] & w_bemask[BTN_W-1:0]);
            for (int n = 0; n < int'(RGB_CH); n++) begin
                if (w_wr && bus.cmd_addr == ADDR_WL'(8 + 2*n))
                    r_color[n] <= (r_color[n] & ~w_bemask[2:0])
                                | (bus.cmd_wdata[2:0] & w_bemask[2:0]);
                if (w_wr && bus.cmd_addr == ADDR_WL'(9 + 2*n))
                    r_dcycle[n] <= (r_dcycle[n] & ~w_bemask[C_PWM_WL-1:0])
                                 | (bus.cmd_wdata[C_PWM_WL-1:0] & w_bemask[C_PWM_WL-1:0]);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rerr  = 1'b0;
        case (bus.cmd_addr)
            C_ADDR_SCRATCH: w_rdata = r_scratch;
            C_ADDR_LEDS:    w_rdata = WL'(r_leds);
            C_ADDR_SW:      w_rdata = WL'(r_sw_sync);
            C_ADDR_BTNLVL:  w_rdata = WL'(r_btn_q);
            C_ADDR_BTNEVT:  w_rdata = WL'(r_btn_evt);
            C_ADDR_IRQEN:   w_rdata = WL'(r_irq_en);
            default:        w_rerr  = 1'b1;
        endcase
        for (int n = 0; n < int'(RGB_CH); n++) begin
            if (bus.cmd_addr == ADDR_WL'(8 + 2*n)) begin
                w_rdata = WL'(r_color[n]);
                w_rerr  = 1'b0;
            end
            if (bus.cmd_addr == ADDR_WL'(9 + 2*n)) begin
                w_rdata = WL'(r_dcycle[n]);
                w_rerr  = 1'b0;
            end
        end
    end

    // Response fields are forced to zero whenever no response is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= w_rd;
            r_rsp_data  <= w_rd ? w_rdata : '0;
            r_rsp_error <= w_rd & w_rerr;
        end
    end

    generate
        for (gi = 0; gi < int'(RGB_CH); gi++) begin : g_pwm
            assign w_pwm[gi] = (r_cnt < r_duty[gi]);
        end
    endgenerate

    // Active duties only reload on the last count so periods are never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rgb <= '0;
            for (int n = 0; n < int'(RGB_CH); n++)
                r_duty[n] <= '0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            for (int n = 0; n < int'(RGB_CH); n++) begin
                if (w_cnt_wrap)
                    r_duty[n] <= r_dcycle[n];
                r_rgb[3*n +: 3] <= r_color[n] & {3{w_pwm[n]}};
            end
        end
    end

    assign leds          = r_leds;
    assign rgb           = r_rgb;
    assign irq           = r_irq;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_error = r_rsp_error;

endmodule

`default_nettype wire
